// File: rtl/axi_txn_sched_pkg.sv
// Shared types and helpers for the AXI transaction scheduler.
package axi_txn_sched_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    LAUNCH   = 2'd1,
    WAIT     = 2'd2,
    COMPLETE = 2'd3
  } state_t;

  // Increment that sticks at the all-ones value of a 'width'-bit counter.
  function automatic logic [31:0] sat_inc(input logic [31:0] val, input int unsigned width);
    logic [31:0] max_val;
    max_val = (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
    return (val >= max_val) ? max_val : val + 32'd1;
  endfunction

endpackage

// File: rtl/axi_rr_arbiter.sv
// Combinational round-robin pick: first asserted request at or after ptr, wrapping.
module axi_rr_arbiter #(
  parameter int N_REQ = 4,
  parameter int IDX_W = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N_REQ-1:0] gnt,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  // Scan from the pointer upward and take the first requester found.
  always_comb begin
    int               cand_i;
    logic [IDX_W-1:0] cand;
    gnt    = '0;
    idx    = '0;
    any    = 1'b0;
    cand_i = 0;
    cand   = '0;
    for (int k = 0; k < N_REQ; k++) begin
      cand_i = (int'(ptr) + k) % N_REQ;
      cand   = IDX_W'(cand_i);
      if (!any && req[cand]) begin
        any       = 1'b1;
        gnt[cand] = 1'b1;
        idx       = cand;
      end
    end
  end

endmodule

// File: rtl/axi_txn_scheduler.sv
// Round-robin scheduler sharing one AXI master transaction engine among N_REQ requesters.
// Optional watchdog in WAIT enabled by defining AXI_TXN_SCHED_TIMEOUT_EN (adds timeout_o).
module axi_txn_scheduler
  import axi_txn_sched_pkg::*;
#(
  parameter int N_REQ       = 4,
  parameter int ADDR_W      = 32,
  parameter int INIT_PULSE  = 2,
  parameter int CNT_W       = 16,
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic                    ACLK,
  input  logic                    ARESETN,
  input  logic [N_REQ-1:0]        req_i,
  input  logic [N_REQ*ADDR_W-1:0] req_addr_i,
  output logic [N_REQ-1:0]        grant_o,
  output logic [N_REQ-1:0]        ack_o,
  output logic [N_REQ-1:0]        err_o,
  output logic                    M_AXI_INIT_AXI_TXN,
  input  logic                    M_AXI_TXN_DONE,
  input  logic                    M_AXI_ERROR,
  output logic [ADDR_W-1:0]       M_AXI_TARGET_BASE,
  output logic                    busy_o,
  output logic [CNT_W-1:0]        txn_cnt_o,
  output logic [CNT_W-1:0]        err_cnt_o
`ifdef AXI_TXN_SCHED_TIMEOUT_EN
  ,
  output logic                    timeout_o
`endif
);

  localparam int IDX_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int PCNT_W = $clog2(INIT_PULSE + 1);

  logic [1:0]        rst_sync;
  logic              rst_n;
  state_t            state_q, state_d;
  logic [IDX_W-1:0]  ptr_q, win_q;
  logic [N_REQ-1:0]  grant_q;
  logic [ADDR_W-1:0] addr_q, sel_addr;
  logic [PCNT_W-1:0] pulse_q;
  logic              done_q, armed_q, err_q;
  logic              done_hit;
  logic [CNT_W-1:0]  txn_cnt_q, err_cnt_q;
  logic [N_REQ-1:0]  arb_gnt;
  logic [IDX_W-1:0]  arb_idx;
  logic              arb_any;
  logic              timeout_hit;

  // Reset asserts asynchronously, releases two clocks after ARESETN rises.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) rst_sync <= 2'b00;
    else          rst_sync <= {rst_sync[0], 1'b1};
  end
  assign rst_n = rst_sync[1];

  axi_rr_arbiter #(.N_REQ(N_REQ), .IDX_W(IDX_W)) u_arb (
    .req (req_i),
    .ptr (ptr_q),
    .gnt (arb_gnt),
    .idx (arb_idx),
    .any (arb_any)
  );

  // Select the arbitration winner's base address.
  always_comb begin
    sel_addr = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (arb_idx == IDX_W'(k)) sel_addr = req_addr_i[k*ADDR_W +: ADDR_W];
    end
  end

  // A completion counts only on a rising done edge after done was seen low in this transaction.
  assign done_hit = (state_q == WAIT) && armed_q && M_AXI_TXN_DONE && !done_q;

`ifdef AXI_TXN_SCHED_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYC + 1);
  logic [WD_W-1:0] wd_q;
  logic            timeout_q;

  assign timeout_hit = (state_q == WAIT) && !done_hit && (wd_q == WD_W'(TIMEOUT_CYC - 1));
  assign timeout_o   = timeout_q;

  // Watchdog counts WAIT cycles; timeout flag is sticky until reset.
  always_ff @(posedge ACLK or negedge rst_n) begin
    if (!rst_n) begin
      wd_q      <= '0;
      timeout_q <= 1'b0;
    end else begin
      wd_q <= (state_q == WAIT) ? wd_q + 1'b1 : '0;
      if (timeout_hit) timeout_q <= 1'b1;
    end
  end
`else
  assign timeout_hit = 1'b0;
`endif

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     if (arb_any) state_d = LAUNCH;
      LAUNCH:   if (pulse_q == PCNT_W'(INIT_PULSE - 1)) state_d = WAIT;
      WAIT:     if (done_hit || timeout_hit) state_d = COMPLETE;
      COMPLETE: state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  // State register plus per-transaction context, done tracking, counters and pointer.
  always_ff @(posedge ACLK or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      win_q     <= '0;
      grant_q   <= '0;
      addr_q    <= '0;
      pulse_q   <= '0;
      done_q    <= 1'b0;
      armed_q   <= 1'b0;
      err_q     <= 1'b0;
      txn_cnt_q <= '0;
      err_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      done_q  <= M_AXI_TXN_DONE;
      case (state_q)
        IDLE: begin
          if (arb_any) begin
            win_q   <= arb_idx;
            grant_q <= arb_gnt;
            addr_q  <= sel_addr;
            pulse_q <= '0;
            armed_q <= 1'b0;
            err_q   <= 1'b0;
          end
        end
        LAUNCH: begin
          pulse_q <= pulse_q + 1'b1;
          if (!M_AXI_TXN_DONE) armed_q <= 1'b1;
        end
        WAIT: begin
          if (!M_AXI_TXN_DONE) armed_q <= 1'b1;
          if (done_hit)         err_q <= M_AXI_ERROR;
          else if (timeout_hit) err_q <= 1'b1;
        end
        COMPLETE: begin
          txn_cnt_q <= CNT_W'(sat_inc(32'(txn_cnt_q), CNT_W));
          if (err_q) err_cnt_q <= CNT_W'(sat_inc(32'(err_cnt_q), CNT_W));
          ptr_q <= (win_q == IDX_W'(N_REQ - 1)) ? '0 : win_q + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign busy_o             = (state_q != IDLE);
  assign grant_o            = busy_o ? grant_q : '0;
  assign ack_o              = (state_q == COMPLETE) ? grant_q : '0;
  assign err_o              = ((state_q == COMPLETE) && err_q) ? grant_q : '0;
  assign M_AXI_INIT_AXI_TXN = (state_q == LAUNCH);
  assign M_AXI_TARGET_BASE  = addr_q;
  assign txn_cnt_o          = txn_cnt_q;
  assign err_cnt_o          = err_cnt_q;

endmodule

// File: tb/tb_axi_txn_scheduler.sv
// Directed self-checking bench for axi_txn_scheduler.
module tb_axi_txn_scheduler;

  localparam int N_REQ       = 4;
  localparam int ADDR_W      = 32;
  localparam int INIT_PULSE  = 2;
  localparam int CNT_W       = 3;
  localparam int TIMEOUT_CYC = 100;

  logic                    ACLK = 1'b0;
  logic                    ARESETN = 1'b0;
  logic [N_REQ-1:0]        req_i = '0;
  logic [N_REQ*ADDR_W-1:0] req_addr_i = '0;
  logic [N_REQ-1:0]        grant_o, ack_o, err_o;
  logic                    M_AXI_INIT_AXI_TXN;
  logic                    M_AXI_TXN_DONE = 1'b0;
  logic                    M_AXI_ERROR = 1'b0;
  logic [ADDR_W-1:0]       M_AXI_TARGET_BASE;
  logic                    busy_o;
  logic [CNT_W-1:0]        txn_cnt_o, err_cnt_o;
`ifdef AXI_TXN_SCHED_TIMEOUT_EN
  logic                    timeout_o;
`endif

  int checks = 0;
  int failures = 0;

  always #5 ACLK = ~ACLK;

  axi_txn_scheduler #(
    .N_REQ(N_REQ), .ADDR_W(ADDR_W), .INIT_PULSE(INIT_PULSE),
    .CNT_W(CNT_W), .TIMEOUT_CYC(TIMEOUT_CYC)
  ) dut (
    .ACLK               (ACLK),
    .ARESETN            (ARESETN),
    .req_i              (req_i),
    .req_addr_i         (req_addr_i),
    .grant_o            (grant_o),
    .ack_o              (ack_o),
    .err_o              (err_o),
    .M_AXI_INIT_AXI_TXN (M_AXI_INIT_AXI_TXN),
    .M_AXI_TXN_DONE     (M_AXI_TXN_DONE),
    .M_AXI_ERROR        (M_AXI_ERROR),
    .M_AXI_TARGET_BASE  (M_AXI_TARGET_BASE),
    .busy_o             (busy_o),
    .txn_cnt_o          (txn_cnt_o),
    .err_cnt_o          (err_cnt_o)
`ifdef AXI_TXN_SCHED_TIMEOUT_EN
    ,
    .timeout_o          (timeout_o)
`endif
  );

  function automatic logic [ADDR_W-1:0] chan_addr(input int k);
    return 32'h4000_0000 + 32'(k) * 32'h0000_1000;
  endfunction

  task automatic apply_reset();
    ARESETN        = 1'b0;
    req_i          = '0;
    M_AXI_TXN_DONE = 1'b0;
    M_AXI_ERROR    = 1'b0;
    repeat (2) @(negedge ACLK);
    ARESETN = 1'b1;
    repeat (4) @(negedge ACLK);
  endtask

  task automatic wait_init(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge ACLK);
      if (M_AXI_INIT_AXI_TXN === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_ack(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge ACLK);
      if (ack_o !== '0) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    ARESETN = 1'b0;
    @(negedge ACLK);
    checks++;
    if ({grant_o, ack_o, err_o, M_AXI_INIT_AXI_TXN, busy_o} !== '0) begin
      failures++;
      $display("FAIL reset_ctrl: got %b expected 0", {grant_o, ack_o, err_o, M_AXI_INIT_AXI_TXN, busy_o});
    end
    checks++;
    if (M_AXI_TARGET_BASE !== '0 || txn_cnt_o !== '0 || err_cnt_o !== '0) begin
      failures++;
      $display("FAIL reset_data: base=%h txn=%0d err=%0d expected all 0", M_AXI_TARGET_BASE, txn_cnt_o, err_cnt_o);
    end
    ARESETN = 1'b1;
    repeat (4) @(negedge ACLK);
  endtask

  task automatic test_single();
    bit ok;
    req_i = 4'b0001;
    wait_init(ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL single_init: INIT never rose"); end
    checks++;
    if (grant_o !== 4'b0001 || M_AXI_TARGET_BASE !== 32'h4000_0000) begin
      failures++;
      $display("FAIL single_grant: grant=%b base=%h expected 0001 40000000", grant_o, M_AXI_TARGET_BASE);
    end
    req_i = '0;
    @(negedge ACLK);
    checks++;
    if (M_AXI_INIT_AXI_TXN !== 1'b1) begin failures++; $display("FAIL single_init2: got %b expected 1", M_AXI_INIT_AXI_TXN); end
    @(negedge ACLK);
    checks++;
    if (M_AXI_INIT_AXI_TXN !== 1'b0) begin failures++; $display("FAIL single_init3: got %b expected 0", M_AXI_INIT_AXI_TXN); end
    repeat (48) @(negedge ACLK);
    checks++;
    if (ack_o !== '0 || grant_o !== 4'b0001) begin
      failures++;
      $display("FAIL single_hold: ack=%b grant=%b expected 0000 0001", ack_o, grant_o);
    end
    M_AXI_TXN_DONE = 1'b1;
    @(negedge ACLK);
    checks++;
    if (ack_o !== 4'b0001 || err_o !== 4'b0000) begin
      failures++;
      $display("FAIL single_ack: ack=%b err=%b expected 0001 0000", ack_o, err_o);
    end
    @(negedge ACLK);
    checks++;
    if (txn_cnt_o !== 3'd1 || busy_o !== 1'b0 || ack_o !== '0) begin
      failures++;
      $display("FAIL single_after: txn=%0d busy=%b ack=%b expected 1 0 0000", txn_cnt_o, busy_o, ack_o);
    end
    M_AXI_TXN_DONE = 1'b0;
    repeat (2) @(negedge ACLK);
  endtask

  task automatic test_round_robin();
    bit ok;
    int exp_idx;
    apply_reset();
    req_i = 4'b1111;
    for (int t = 0; t < 8; t++) begin
      exp_idx = t % N_REQ;
      wait_init(ok);
      checks++;
      if (!ok) begin failures++; $display("FAIL rr_init_%0d: INIT never rose", t); end
      checks++;
      if (grant_o !== N_REQ'(1 << exp_idx) || M_AXI_TARGET_BASE !== chan_addr(exp_idx)) begin
        failures++;
        $display("FAIL rr_grant_%0d: grant=%b base=%h expected %b %h", t, grant_o, M_AXI_TARGET_BASE,
                 N_REQ'(1 << exp_idx), chan_addr(exp_idx));
      end
      repeat (3) @(negedge ACLK);
      M_AXI_TXN_DONE = 1'b1;
      wait_ack(ok);
      checks++;
      if (!ok || ack_o !== N_REQ'(1 << exp_idx)) begin
        failures++;
        $display("FAIL rr_ack_%0d: ack=%b expected %b", t, ack_o, N_REQ'(1 << exp_idx));
      end
      if (t == 7) req_i = '0;
      @(negedge ACLK);
      checks++;
      if (busy_o !== 1'b0 || grant_o !== '0) begin
        failures++;
        $display("FAIL rr_idle_%0d: busy=%b grant=%b expected 0 0000", t, busy_o, grant_o);
      end
      M_AXI_TXN_DONE = 1'b0;
    end
    checks++;
    if (txn_cnt_o !== 3'd7) begin failures++; $display("FAIL rr_sat: txn=%0d expected 7", txn_cnt_o); end
  endtask

  task automatic test_error();
    bit ok;
    apply_reset();
    req_i = 4'b0100;
    wait_init(ok);
    checks++;
    if (!ok || grant_o !== 4'b0100) begin failures++; $display("FAIL err_grant: grant=%b expected 0100", grant_o); end
    req_i = '0;
    repeat (3) @(negedge ACLK);
    M_AXI_TXN_DONE = 1'b1;
    M_AXI_ERROR    = 1'b1;
    wait_ack(ok);
    checks++;
    if (!ok || ack_o !== 4'b0100 || err_o !== 4'b0100) begin
      failures++;
      $display("FAIL err_pulse: ack=%b err=%b expected 0100 0100", ack_o, err_o);
    end
    @(negedge ACLK);
    checks++;
    if (err_cnt_o !== 3'd1 || txn_cnt_o !== 3'd1 || err_o !== '0) begin
      failures++;
      $display("FAIL err_cnt: errcnt=%0d txn=%0d err=%b expected 1 1 0000", err_cnt_o, txn_cnt_o, err_o);
    end
    M_AXI_TXN_DONE = 1'b0;
    M_AXI_ERROR    = 1'b0;
  endtask

  task automatic test_stale_done();
    bit ok;
    int acks;
    int ack_at;
    apply_reset();
    M_AXI_TXN_DONE = 1'b1;
    @(negedge ACLK);
    req_i = 4'b0001;
    wait_init(ok);
    req_i  = '0;
    acks   = 0;
    ack_at = -1;
    for (int off = 1; off <= 30; off++) begin
      @(negedge ACLK);
      if (ack_o !== '0) begin
        acks++;
        ack_at = off;
      end
      if (off == 3)  M_AXI_TXN_DONE = 1'b0;
      if (off == 20) M_AXI_TXN_DONE = 1'b1;
    end
    checks++;
    if (!ok || acks != 1 || ack_at != 21) begin
      failures++;
      $display("FAIL stale_done: acks=%0d at=+%0d expected 1 at +21", acks, ack_at);
    end
    M_AXI_TXN_DONE = 1'b0;
    @(negedge ACLK);
  endtask

  task automatic test_reset_mid_wait();
    bit ok;
    int acks;
    req_i = 4'b0010;
    wait_init(ok);
    req_i = '0;
    repeat (5) @(negedge ACLK);
    checks++;
    if (!ok || busy_o !== 1'b1 || M_AXI_INIT_AXI_TXN !== 1'b0) begin
      failures++;
      $display("FAIL midrst_wait: busy=%b init=%b expected 1 0", busy_o, M_AXI_INIT_AXI_TXN);
    end
    ARESETN = 1'b0;
    #1;
    checks++;
    if (grant_o !== '0 || M_AXI_INIT_AXI_TXN !== 1'b0 || busy_o !== 1'b0 || ack_o !== '0) begin
      failures++;
      $display("FAIL midrst_async: grant=%b init=%b busy=%b ack=%b expected all 0",
               grant_o, M_AXI_INIT_AXI_TXN, busy_o, ack_o);
    end
    M_AXI_TXN_DONE = 1'b1;
    @(negedge ACLK);
    ARESETN = 1'b1;
    acks = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge ACLK);
      if (ack_o !== '0 || busy_o !== 1'b0) acks++;
    end
    checks++;
    if (acks != 0) begin failures++; $display("FAIL midrst_noack: activity=%0d expected 0", acks); end
    checks++;
    if (txn_cnt_o !== '0 || err_cnt_o !== '0) begin
      failures++;
      $display("FAIL midrst_cnt: txn=%0d err=%0d expected 0 0", txn_cnt_o, err_cnt_o);
    end
    M_AXI_TXN_DONE = 1'b0;
    @(negedge ACLK);
  endtask

`ifdef AXI_TXN_SCHED_TIMEOUT_EN
  task automatic test_timeout();
    bit ok;
    int ack_at;
    logic [N_REQ-1:0] err_seen;
    apply_reset();
    req_i = 4'b0001;
    wait_init(ok);
    req_i    = '0;
    ack_at   = -1;
    err_seen = '0;
    for (int off = 1; off <= 110; off++) begin
      @(negedge ACLK);
      if (ack_o !== '0 && ack_at < 0) begin
        ack_at   = off;
        err_seen = err_o;
      end
    end
    checks++;
    if (!ok || ack_at != 102 || err_seen !== 4'b0001 || timeout_o !== 1'b1) begin
      failures++;
      $display("FAIL timeout: at=+%0d err=%b tmo=%b expected +102 0001 1", ack_at, err_seen, timeout_o);
    end
    req_i = 4'b0001;
    wait_init(ok);
    req_i = '0;
    repeat (3) @(negedge ACLK);
    M_AXI_TXN_DONE = 1'b1;
    wait_ack(ok);
    checks++;
    if (!ok || ack_o !== 4'b0001 || err_o !== '0 || timeout_o !== 1'b1) begin
      failures++;
      $display("FAIL timeout_next: ack=%b err=%b tmo=%b expected 0001 0000 1", ack_o, err_o, timeout_o);
    end
    M_AXI_TXN_DONE = 1'b0;
    @(negedge ACLK);
  endtask
`endif

  initial begin
    for (int k = 0; k < N_REQ; k++) req_addr_i[k*ADDR_W +: ADDR_W] = chan_addr(k);
    test_reset();
    test_single();
    test_round_robin();
    test_error();
    test_stale_done();
    test_reset_mid_wait();
`ifdef AXI_TXN_SCHED_TIMEOUT_EN
    test_timeout();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish within time limit");
    $fatal(1, "bench time limit exceeded");
  end

endmodule
